// File: rtl/csa_acc_pkg.sv
// Shared types and elaboration-time helpers for the CSA stream accumulator.
package csa_acc_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  function automatic int unsigned calc_nch(input int unsigned dw, input int unsigned cw);
    return dw / cw;
  endfunction

  // Never returns 0 so a single-chunk configuration still gets a 1-bit index.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/cpa_chunk.sv
// Combinational CW-bit carry-propagate adder slice with carry-in and carry-out.
module cpa_chunk #(
  parameter int unsigned CW = 16
) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_c,
  output logic [CW-1:0] o_s,
  output logic          o_c
);

  assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{CW{1'b0}}, i_c};

endmodule

// File: rtl/csa_stream_accumulator.sv
// Folds an operand stream into a redundant sum/carry pair, then resolves it to
// binary CW bits per cycle and presents the result on a valid/ready output.
module csa_stream_accumulator
  import csa_acc_pkg::*;
#(
  parameter int unsigned DW   = 64,
  parameter int unsigned CW   = 16,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [CNTW-1:0] out_count
);

  localparam int unsigned NCH = calc_nch(DW, CW);
  localparam int unsigned KW  = clog2(NCH);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [DW-1:0]   r_acc_s;
  logic [DW-1:0]   r_acc_c;
  logic [DW-1:0]   r_res;
  logic [CNTW-1:0] r_cnt;
  logic [KW-1:0]   r_k;
  logic            r_cf;
  logic            r_rdy;

  logic            w_accept;
  logic            w_k_last;
  logic [DW-1:0]   w_s;
  logic [DW-1:0]   w_c;
  logic [CW-1:0]   w_ch_a;
  logic [CW-1:0]   w_ch_b;
  logic [CW-1:0]   w_ch_s;
  logic            w_ch_co;

  // r_rdy keeps in_ready low through the reset cycles themselves.
  assign in_ready  = r_rdy & (r_state == ACCUM);
  assign out_valid = (r_state == OUTPUT);
  assign out_data  = r_res;
  assign out_count = r_cnt;

  assign w_accept = in_valid & in_ready;
  assign w_k_last = (r_k == KW'(NCH - 1));

  assign w_s = r_acc_s ^ r_acc_c ^ in_data;
  assign w_c = (r_acc_s & r_acc_c) | (r_acc_s & in_data) | (r_acc_c & in_data);

  assign w_ch_a = r_acc_s[r_k*CW +: CW];
  assign w_ch_b = r_acc_c[r_k*CW +: CW];

  cpa_chunk #(.CW(CW)) u_cpa (
    .i_a (w_ch_a),
    .i_b (w_ch_b),
    .i_c (r_cf),
    .o_s (w_ch_s),
    .o_c (w_ch_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_accept && in_last) w_state_nxt = RESOLVE;
      RESOLVE: if (w_k_last)            w_state_nxt = OUTPUT;
      OUTPUT:  if (out_ready)           w_state_nxt = ACCUM;
      default:                          w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_s <= '0;
      r_acc_c <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_k     <= '0;
      r_cf    <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_acc_s <= w_s;
            r_acc_c <= {w_c[DW-2:0], 1'b0};
            r_cnt   <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
            if (in_last) begin
              r_k  <= '0;
              r_cf <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          r_res[r_k*CW +: CW] <= w_ch_s;
          r_cf                <= w_ch_co;
          r_k                 <= w_k_last ? '0 : r_k + 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            r_acc_s <= '0;
            r_acc_c <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Randomized and directed bench for csa_stream_accumulator against a plain
// arithmetic sum/count reference model.
module tb_csa_stream_accumulator;

  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 4;
  localparam int unsigned CNTW = 3;
  localparam int unsigned NCH  = DW / CW;
  localparam int unsigned CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [CNTW-1:0] out_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [DW-1:0] q_ops[$];

  always #5 clk = ~clk;

  csa_stream_accumulator #(.DW(DW), .CW(CW), .CNTW(CNTW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends q_ops as one sum, then drains the result after 'hold' stalled cycles.
  task automatic run_sum(input int unsigned hold);
    logic [DW-1:0] exp_sum;
    int unsigned   exp_cnt;
    int unsigned   guard;
    int unsigned   lat;
    exp_sum = '0;
    foreach (q_ops[i]) exp_sum = exp_sum + q_ops[i];
    exp_cnt = (q_ops.size() > CMAX) ? CMAX : q_ops.size();

    foreach (q_ops[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_last  = 1'b1;
        step();
      end
      in_valid = 1'b1;
      in_data  = q_ops[i];
      in_last  = (i == q_ops.size() - 1);
      guard = 0;
      while (!in_ready && guard < 20) begin
        step();
        guard++;
      end
      if (guard >= 20) check_val("in_ready_timeout", 0, 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = DW'($urandom);
    check_val("in_ready_after_last", 32'(in_ready), 0);

    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    check_val("latency", lat, NCH);

    out_ready = 1'b0;
    for (int unsigned h = 0; h < hold; h++) begin
      check_val("hold_valid", 32'(out_valid), 1);
      check_val("hold_in_ready", 32'(in_ready), 0);
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      in_last  = 1'(($urandom_range(0, 1)));
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_val("out_valid", 32'(out_valid), 1);
    check_val("out_data", 32'(out_data), 32'(exp_sum));
    check_val("out_count", 32'(out_count), exp_cnt);
    check_val("in_ready_in_output", 32'(in_ready), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val("valid_after_hs", 32'(out_valid), 0);
    check_val("ready_after_hs", 32'(in_ready), 1);
    check_val("count_cleared", 32'(out_count), 0);
  endtask

  initial begin
    int unsigned bad;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check_val("rst_in_ready", 32'(in_ready), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_out_data", 32'(out_data), 0);
    check_val("rst_out_count", 32'(out_count), 0);
    rst_n = 1'b1;
    step();
    check_val("ready_after_rst", 32'(in_ready), 1);

    q_ops = '{16'h005A};                 run_sum(0);
    q_ops = '{16'h00FF, 16'h0001, 16'h0080}; run_sum(1);
    q_ops = '{16'h0FFF, 16'h0001};       run_sum(5);
    q_ops = '{16'hFFFF, 16'h0001};       run_sum(2);
    q_ops = {};
    for (int i = 0; i < 5; i++) q_ops.push_back(16'h0001);
    run_sum(0);
    q_ops = {};
    for (int i = 0; i < 9; i++) q_ops.push_back(16'h0001);
    run_sum(3);

    // Reset while the second chunk is being resolved.
    in_valid = 1'b1;
    in_data  = 16'h0FFF;
    in_last  = 1'b0;
    step();
    in_data  = 16'h0001;
    in_last  = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check_val("midrst_out_valid", 32'(out_valid), 0);
    check_val("midrst_out_data", 32'(out_data), 0);
    check_val("midrst_out_count", 32'(out_count), 0);
    check_val("midrst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    step();
    check_val("midrst_ready_after", 32'(in_ready), 1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) bad++;
      step();
    end
    check_val("midrst_no_valid", bad, 0);
    q_ops = '{16'h0003};
    run_sum(0);

    for (int t = 0; t < 25; t++) begin
      q_ops = {};
      for (int unsigned b = 0; b < $urandom_range(1, 12); b++) q_ops.push_back(DW'($urandom));
      run_sum($urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
